midi_parser: RTL and testbench
==============================

# midi_parser

Byte-level MIDI message controller sitting directly behind the MIDI RX frontend. It consumes received bytes and tracks status and running status. It filters by channel and assembles complete channel-voice messages into typed events for the synth core, using a valid/ready output handshake. Realtime bytes are decoded without disturbing message assembly.

## Interface
- VEL0_IS_OFF, 1: when 1, Note-On with velocity 0 is emitted as NOTE_OFF.
- clk_i  in  1  system clock.
- nrst_i  in  1  reset, synchronous, active-low.
- byteValid_i  in  1  single-cycle strobe; byte_i valid this cycle.
- byte_i  in  8  received MIDI byte.
- channel_i  in  4  channel to accept (0..15), sampled per message.
- omni_i  in  1  1 = accept all channels.
- evtValid_o  out  1  event pending.
- evtReady_i  in  1  consumer accepts event when evtValid_o && evtReady_i.
- evtType_o  out  2  0 NOTE_OFF, 1 NOTE_ON, 2 CTRL_CHANGE, 3 PITCH_BEND.
- evtChannel_o  out  4  channel of event.
- evtData1_o  out  7  note / controller number / bend LSB.
- evtData2_o  out  7  velocity / value / bend MSB.
- overrun_o  out  1  sticky: an event was dropped.
- clrOverrun_i  in  1  clears overrun_o.
- rtTick_o  out  1  one-cycle pulse per 0xF8 (timing clock).
- rtStart_o  out  1  one-cycle pulse per 0xFA or 0xFB (start/continue).
- rtStop_o  out  1  one-cycle pulse per 0xFC.

## Operation
- States: IDLE (no running status), DATA1, DATA2, DISCARD.
- Registers: status nibble, channel, match flag, expected length (1 or 2), d1.
- Byte classes are evaluated only on byteValid_i. Without byteValid_i nothing changes except handshake and pulses.
- Realtime byte (0xF8–0xFF), any state: pulse the matching rt output; state, running status and partial data are untouched. Other realtime values are ignored.
- System common / SysEx (0xF0–0xF7): clear running status, go to DISCARD.
- Channel status (0x80–0xEF): latch status, channel and match = omni_i || (low nibble == channel_i). Length is 1 for 0xC/0xD and 2 otherwise. Go to DATA1. This aborts any partial message silently.
- Data byte (bit7 = 0):
  - IDLE/DISCARD: dropped.
  - DATA1: latch d1. For length 1, complete and stay in DATA1. Otherwise go to DATA2.
  - DATA2: complete with d2 = byte and return to DATA1. Running status is kept.
- Completion emits an event only if match = 1 and status is 0x8, 0x9, 0xB or 0xE. 0xA, 0xC and 0xD are parsed for framing but never emitted.
- Type mapping: 0x8 → NOTE_OFF; 0x9 → NOTE_ON, or NOTE_OFF if d2 == 0 and VEL0_IS_OFF; 0xB → CTRL_CHANGE; 0xE → PITCH_BEND. Data is passed unmodified, 7 bits each.
- Output register: loads on emit if evtValid_o = 0, or if the pending event is accepted in the same cycle. Otherwise the new event is dropped, the held event is unchanged, and overrun_o is set.
- overrun_o: set has priority over clrOverrun_i in the same cycle.

## Timing
- Reset (nrst_i low at posedge): state IDLE, running status cleared. All outputs are 0 (evtValid_o, evt fields, overrun_o, rt pulses). Reset mid-message discards it.
- Event latency: evtValid_o rises the cycle after the strobe of the completing byte.
- evtValid_o and the evt fields are stable until the handshake. evtValid_o falls the cycle after acceptance unless a new event loads in that same cycle.
- rt pulses: exactly one cycle, the cycle after the strobe.
- Back-to-back strobes on consecutive cycles must be handled. Throughput is one byte per cycle.

## Structure
- Shared package / global.v:
  - event-type encodings (EVT_NOTE_OFF..EVT_PITCH_BEND);
  - status nibble constants;
  - realtime byte constants;
  - FSM state encodings.
- Single module, no sub-module. Length/support decode is a local function.
- Instantiated next to rx. byteValid_i is driven by rx's dataReady_o, byte_i by midiData_o.

## Test plan
- Basic note-on: channel_i = 3; send 0x93 0x3C 0x64, evtReady_i = 1 → one event {NOTE_ON, ch 3, 0x3C, 0x64}, evtValid_o high for one cycle.
- Running status and velocity 0: send 0x90 0x40 0x7F 0x40 0x00 with omni → NOTE_ON {0x40, 0x7F} then NOTE_OFF {0x40, 0x00}.
- Channel filter and unsupported status:
  - channel_i = 1, omni off; send 0x92 0x10 0x20 → no event.
  - Send 0xC1 0x05, then 0xB1 0x07 0x50 → only CTRL_CHANGE {ch 1, 0x07, 0x50}.
- Realtime interleave: send 0xE0 0x00 0xF8 0x40 → rtTick_o one pulse, then PITCH_BEND {0x00, 0x40}. Also: SysEx 0xF0 0x01 0xF7 followed by 0x45 → no event.
- Backpressure:
  - evtReady_i = 0; complete two messages → first held unchanged, overrun_o = 1.
  - clrOverrun_i → 0. Completion coinciding with clrOverrun_i → overrun_o stays 1.
- Reset mid-message: send 0x90 0x3C, pulse nrst_i low, send 0x64 → no event, all outputs 0.

Source files
------------

// File: rtl/midi_parser_pkg.sv
// Shared encodings for the MIDI byte parser: event types, status nibbles,
// realtime bytes and parser states.
package midi_parser_pkg;

    localparam logic [1:0] EVT_NOTE_OFF    = 2'd0;
    localparam logic [1:0] EVT_NOTE_ON     = 2'd1;
    localparam logic [1:0] EVT_CTRL_CHANGE = 2'd2;
    localparam logic [1:0] EVT_PITCH_BEND  = 2'd3;

    localparam logic [3:0] STAT_NOTE_OFF = 4'h8;
    localparam logic [3:0] STAT_NOTE_ON  = 4'h9;
    localparam logic [3:0] STAT_POLY_AT  = 4'hA;
    localparam logic [3:0] STAT_CTRL     = 4'hB;
    localparam logic [3:0] STAT_PROG     = 4'hC;
    localparam logic [3:0] STAT_CH_AT    = 4'hD;
    localparam logic [3:0] STAT_BEND     = 4'hE;

    localparam logic [7:0] RT_TICK     = 8'hF8;
    localparam logic [7:0] RT_START    = 8'hFA;
    localparam logic [7:0] RT_CONTINUE = 8'hFB;
    localparam logic [7:0] RT_STOP     = 8'hFC;

    typedef enum logic [1:0] {
        StIdle,
        StData1,
        StData2,
        StDiscard
    } state_t;

endpackage

// File: rtl/midi_parser.sv
// MIDI byte parser: tracks running status, filters by channel and assembles
// channel-voice messages into events behind a valid/ready output register.
module midi_parser
    import midi_parser_pkg::*;
#(
    parameter bit VEL0_IS_OFF = 1'b1
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       byteValid_i,
    input  logic [7:0] byte_i,
    input  logic [3:0] channel_i,
    input  logic       omni_i,
    output logic       evtValid_o,
    input  logic       evtReady_i,
    output logic [1:0] evtType_o,
    output logic [3:0] evtChannel_o,
    output logic [6:0] evtData1_o,
    output logic [6:0] evtData2_o,
    output logic       overrun_o,
    input  logic       clrOverrun_i,
    output logic       rtTick_o,
    output logic       rtStart_o,
    output logic       rtStop_o
);

    function automatic logic f_is_len2(input logic [3:0] s);
        return !((s == STAT_PROG) || (s == STAT_CH_AT));
    endfunction

    function automatic logic f_supported(input logic [3:0] s);
        return (s == STAT_NOTE_OFF) || (s == STAT_NOTE_ON) ||
               (s == STAT_CTRL) || (s == STAT_BEND);
    endfunction

    function automatic logic [1:0] f_type(input logic [3:0] s, input logic [6:0] d2);
        logic [1:0] t;
        t = EVT_NOTE_OFF;
        case (s)
            STAT_NOTE_ON: t = (VEL0_IS_OFF && (d2 == 7'd0)) ? EVT_NOTE_OFF : EVT_NOTE_ON;
            STAT_CTRL:    t = EVT_CTRL_CHANGE;
            STAT_BEND:    t = EVT_PITCH_BEND;
            default:      t = EVT_NOTE_OFF;
        endcase
        return t;
    endfunction

    state_t     r_state;
    logic [3:0] r_status;
    logic [3:0] r_chan;
    logic       r_match;
    logic       r_len2;
    logic [6:0] r_d1;

    logic       w_is_rt;
    logic       w_is_sys;
    logic       w_is_data;
    logic       w_complete;
    logic       w_emit;
    logic       w_load;
    logic [6:0] w_cd1;
    logic [6:0] w_cd2;

    always_comb begin
        w_is_rt    = (byte_i[7:3] == 5'b11111);
        w_is_sys   = (byte_i[7:4] == 4'hF) && !w_is_rt;
        w_is_data  = !byte_i[7];
        w_complete = byteValid_i && w_is_data &&
                     (((r_state == StData1) && !r_len2) || (r_state == StData2));
        // One-byte messages are never emitted, so their d2 is irrelevant.
        w_cd1      = (r_state == StData2) ? r_d1 : byte_i[6:0];
        w_cd2      = (r_state == StData2) ? byte_i[6:0] : 7'd0;
        w_emit     = w_complete && r_match && f_supported(r_status);
        w_load     = w_emit && (!evtValid_o || evtReady_i);
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            r_state      <= StIdle;
            r_status     <= 4'd0;
            r_chan       <= 4'd0;
            r_match      <= 1'b0;
            r_len2       <= 1'b0;
            r_d1         <= 7'd0;
            evtValid_o   <= 1'b0;
            evtType_o    <= 2'd0;
            evtChannel_o <= 4'd0;
            evtData1_o   <= 7'd0;
            evtData2_o   <= 7'd0;
            overrun_o    <= 1'b0;
            rtTick_o     <= 1'b0;
            rtStart_o    <= 1'b0;
            rtStop_o     <= 1'b0;
        end else begin
            rtTick_o  <= byteValid_i && (byte_i == RT_TICK);
            rtStart_o <= byteValid_i && ((byte_i == RT_START) || (byte_i == RT_CONTINUE));
            rtStop_o  <= byteValid_i && (byte_i == RT_STOP);

            if (w_load) begin
                evtValid_o   <= 1'b1;
                evtType_o    <= f_type(r_status, w_cd2);
                evtChannel_o <= r_chan;
                evtData1_o   <= w_cd1;
                evtData2_o   <= w_cd2;
            end else if (evtValid_o && evtReady_i) begin
                evtValid_o <= 1'b0;
            end

            if (w_emit && !w_load) begin
                overrun_o <= 1'b1;
            end else if (clrOverrun_i) begin
                overrun_o <= 1'b0;
            end

            // Realtime bytes fall through every branch and leave the parser untouched.
            if (byteValid_i && !w_is_rt) begin
                if (w_is_sys) begin
                    r_state <= StDiscard;
                end else if (!w_is_data) begin
                    r_status <= byte_i[7:4];
                    r_chan   <= byte_i[3:0];
                    r_match  <= omni_i || (byte_i[3:0] == channel_i);
                    r_len2   <= f_is_len2(byte_i[7:4]);
                    r_state  <= StData1;
                end else begin
                    case (r_state)
                        StData1: begin
                            r_d1 <= byte_i[6:0];
                            if (r_len2) begin
                                r_state <= StData2;
                            end
                        end
                        StData2: r_state <= StData1;
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Randomised and directed bench for midi_parser with a message-level reference
// model feeding event and realtime scoreboards.
module tb_midi_parser;

    logic       clk = 1'b0;
    logic       nrst_i;
    logic       byteValid_i;
    logic [7:0] byte_i;
    logic [3:0] channel_i;
    logic       omni_i;
    logic       evtValid_o;
    logic       evtReady_i;
    logic [1:0] evtType_o;
    logic [3:0] evtChannel_o;
    logic [6:0] evtData1_o;
    logic [6:0] evtData2_o;
    logic       overrun_o;
    logic       clrOverrun_i;
    logic       rtTick_o;
    logic       rtStart_o;
    logic       rtStop_o;

    always #5 clk = ~clk;

    midi_parser #(.VEL0_IS_OFF(1'b1)) dut (
        .clk_i        (clk),
        .nrst_i       (nrst_i),
        .byteValid_i  (byteValid_i),
        .byte_i       (byte_i),
        .channel_i    (channel_i),
        .omni_i       (omni_i),
        .evtValid_o   (evtValid_o),
        .evtReady_i   (evtReady_i),
        .evtType_o    (evtType_o),
        .evtChannel_o (evtChannel_o),
        .evtData1_o   (evtData1_o),
        .evtData2_o   (evtData2_o),
        .overrun_o    (overrun_o),
        .clrOverrun_i (clrOverrun_i),
        .rtTick_o     (rtTick_o),
        .rtStart_o    (rtStart_o),
        .rtStop_o     (rtStop_o)
    );

    typedef struct packed {
        logic [1:0] t;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
    } evt_t;

    evt_t sb_q[$];
    int   rt_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    // Reference model: running status byte (0 = none) and collected data bytes.
    logic [7:0] m_rs;
    logic       m_match;
    logic [6:0] m_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rs    = 8'h00;
        m_match = 1'b0;
        m_data.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [3:0] hi;
        int         need;
        evt_t       e;
        if (b >= 8'hF8) begin
            if (b == 8'hF8) rt_q.push_back(0);
            else if (b == 8'hFA || b == 8'hFB) rt_q.push_back(1);
            else if (b == 8'hFC) rt_q.push_back(2);
        end else if (b >= 8'hF0) begin
            m_rs = 8'h00;
            m_data.delete();
        end else if (b[7]) begin
            m_rs    = b;
            m_match = omni_i || (b[3:0] == channel_i);
            m_data.delete();
        end else if (m_rs != 8'h00) begin
            hi   = m_rs[7:4];
            need = (hi == 4'hC || hi == 4'hD) ? 1 : 2;
            m_data.push_back(b[6:0]);
            if (m_data.size() == need) begin
                if (m_match && (hi == 4'h8 || hi == 4'h9 || hi == 4'hB || hi == 4'hE)) begin
                    e.ch = m_rs[3:0];
                    e.d1 = m_data[0];
                    e.d2 = m_data[1];
                    case (hi)
                        4'h8:    e.t = 2'd0;
                        4'h9:    e.t = (m_data[1] == 7'd0) ? 2'd0 : 2'd1;
                        4'hB:    e.t = 2'd2;
                        default: e.t = 2'd3;
                    endcase
                    sb_q.push_back(e);
                end
                m_data.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_i      = b;
        byteValid_i = 1'b1;
        model_byte(b);
        @(posedge clk);
        #1;
        byteValid_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, evtValid_o}, 32'd0);
        check({tag, "_fields"}, {12'd0, evtType_o, evtChannel_o, evtData1_o, evtData2_o}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun_o}, 32'd0);
        check({tag, "_rt"}, {29'd0, rtTick_o, rtStart_o, rtStop_o}, 32'd0);
    endtask

    always @(negedge clk) begin
        evt_t e;
        int   r;
        if (mon_en) begin
            if (evtValid_o && evtReady_i) begin
                if (sb_q.size() == 0) begin
                    check("evt_unexpected", {12'd0, evtType_o, evtChannel_o, evtData1_o,
                          evtData2_o}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("evt", {12'd0, evtType_o, evtChannel_o, evtData1_o, evtData2_o},
                          {12'd0, e});
                end
            end
            if (rtTick_o || rtStart_o || rtStop_o) begin
                if (rt_q.size() == 0) begin
                    check("rt_unexpected", {29'd0, rtTick_o, rtStart_o, rtStop_o}, 32'd0);
                end else begin
                    r = rt_q.pop_front();
                    check("rt", {29'd0, rtTick_o, rtStart_o, rtStop_o},
                          (r == 0) ? 32'd4 : (r == 1) ? 32'd2 : 32'd1);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        nrst_i       = 1'b0;
        byteValid_i  = 1'b0;
        byte_i       = 8'h00;
        channel_i    = 4'd0;
        omni_i       = 1'b0;
        evtReady_i   = 1'b1;
        clrOverrun_i = 1'b0;
        model_reset();
        idle(3);
        check_all_zero("reset");
        nrst_i = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // Basic note-on on channel 3.
        channel_i = 4'd3;
        send_byte(8'h93); send_byte(8'h3C); send_byte(8'h64);
        idle(1);
        check("note_on_valid_one_cycle", {31'd0, evtValid_o}, 32'd0);

        // Running status with velocity 0.
        omni_i = 1'b1;
        send_byte(8'h90); send_byte(8'h40); send_byte(8'h7F);
        send_byte(8'h40); send_byte(8'h00);
        idle(2);

        // Channel filter and unsupported status.
        omni_i = 1'b0;
        channel_i = 4'd1;
        send_byte(8'h92); send_byte(8'h10); send_byte(8'h20);
        send_byte(8'hC1); send_byte(8'h05);
        send_byte(8'hB1); send_byte(8'h07); send_byte(8'h50);
        idle(2);

        // Realtime interleave and SysEx discard.
        omni_i = 1'b1;
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'hF8); send_byte(8'h40);
        send_byte(8'hF0); send_byte(8'h01); send_byte(8'hF7); send_byte(8'h45);
        send_byte(8'hFA); send_byte(8'hFB); send_byte(8'hFC); send_byte(8'hFE);
        idle(2);

        // Backpressure: second event dropped, first held.
        evtReady_i = 1'b0;
        send_byte(8'h95); send_byte(8'h30); send_byte(8'h11);
        send_byte(8'h31); send_byte(8'h22);
        void'(sb_q.pop_back());
        idle(2);
        check("bp_overrun_set", {31'd0, overrun_o}, 32'd1);
        check("bp_held_valid", {31'd0, evtValid_o}, 32'd1);
        check("bp_held_event", {12'd0, evtType_o, evtChannel_o, evtData1_o, evtData2_o},
              {12'd0, 2'd1, 4'd5, 7'h30, 7'h11});
        evtReady_i = 1'b1;
        idle(2);
        clrOverrun_i = 1'b1;
        idle(1);
        clrOverrun_i = 1'b0;
        check("overrun_cleared", {31'd0, overrun_o}, 32'd0);

        // Completion coinciding with a clear keeps overrun set.
        evtReady_i = 1'b0;
        send_byte(8'h41); send_byte(8'h33);
        send_byte(8'h42);
        clrOverrun_i = 1'b1;
        send_byte(8'h44);
        clrOverrun_i = 1'b0;
        void'(sb_q.pop_back());
        check("overrun_set_beats_clear", {31'd0, overrun_o}, 32'd1);
        evtReady_i = 1'b1;
        idle(2);
        clrOverrun_i = 1'b1;
        idle(1);
        clrOverrun_i = 1'b0;

        // Reset mid-message discards it and clears every output.
        send_byte(8'h90); send_byte(8'h3C);
        nrst_i = 1'b0;
        idle(1);
        nrst_i = 1'b1;
        model_reset();
        check_all_zero("mid_reset");
        send_byte(8'h64);
        idle(2);
        check("post_reset_no_event", {31'd0, evtValid_o}, 32'd0);

        // Randomised byte stream, consumer always ready.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                channel_i = 4'($urandom_range(0, 15));
                omni_i    = ($urandom_range(0, 3) == 0);
            end
            r = $urandom_range(0, 99);
            if (r < 50)      b = 8'($urandom_range(0, 127));
            else if (r < 78) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))};
            else if (r < 92) b = 8'($urandom_range(8'hF8, 8'hFF));
            else             b = 8'($urandom_range(8'hF0, 8'hF7));
            send_byte(b);
            if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
        end

        for (int i = 0; i < 50 && (sb_q.size() != 0 || rt_q.size() != 0); i++) idle(1);
        check("evt_queue_drained", sb_q.size(), 32'd0);
        check("rt_queue_drained", rt_q.size(), 32'd0);
        check("random_no_overrun", {31'd0, overrun_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
